mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
// - Sits directly downstream of the request unit: takes instruction fetch (iREN) and
//   data (dREN/dWEN) requests from the datapath and serialises them onto the single RAM port.
// - Returns ihit/dhit one-cycle pulses (dhit feeds the request unit) with registered load data.
// - Data has priority over fetch; a watchdog ends hung RAM transactions.
// PARAMETERS
// - ADDR_W       32  address width (iaddr, daddr, ramaddr)
// - DATA_W       32  data width (dstore, ramstore, ramload, iload, dload)
// - TIMEOUT_CYC  64  max cycles in a RAM state before forced completion; 0 = watchdog off
// PORTS
// - CLK        in   1       clock, all state updates on rising edge
// - nRST       in   1       reset, synchronous, active-low
// - iREN       in   1       instruction fetch request
// - iaddr      in   ADDR_W  fetch address
// - dREN       in   1       data read request (from request unit dmemREN)
// - dWEN       in   1       data write request (from request unit dmemWEN)
// - daddr      in   ADDR_W  data address
// - dstore     in   DATA_W  write data
// - ihit       out  1       one-cycle pulse: fetch complete, iload valid
// - iload      out  DATA_W  fetched instruction, held until next fetch completes
// - dhit       out  1       one-cycle pulse: data access complete, dload valid on reads
// - dload      out  DATA_W  read data, held until next data read completes
// - ramREN     out  1       RAM read strobe
// - ramWEN     out  1       RAM write strobe
// - ramaddr    out  ADDR_W  RAM address
// - ramstore   out  DATA_W  RAM write data
// - ramload    in   DATA_W  RAM read data, valid when ram_ready=1
// - ram_ready  in   1       RAM completes current access this cycle
// - timeout    out  1       sticky: a watchdog expiry occurred; cleared only by reset
// - icount     out  32      completed fetches (PERF_CNT_EN)
// - dcount     out  32      completed data accesses (PERF_CNT_EN)
// - stallcount out  32      cycles with iREN|dREN|dWEN high and no hit (PERF_CNT_EN)
// BEHAVIOUR
// - Reset: nRST=0 at a rising CLK edge -> state IDLE; ihit,dhit,ramREN,ramWEN,timeout=0;
//   ramaddr,ramstore,iload,dload=0; watchdog and perf counters=0. Aborts any access.
// - States: IDLE, DREQ, IREQ, RESP.
// - IDLE: if dREN|dWEN -> DREQ, else if iREN -> IREQ, else stay. On leaving IDLE latch
//   address, store data and op (write if dWEN, regardless of dREN) into internal regs.
// - DREQ/IREQ: ramaddr/ramstore from latched regs; ramWEN=1 for latched write, else ramREN=1;
//   never both. Strobes are registered: request seen in cycle N -> strobe high from N+1.
// - On ram_ready=1 in DREQ/IREQ: capture ramload into dload (data read) or iload (fetch),
//   go to RESP; strobes drop at that edge. Writes leave dload unchanged.
// - RESP: exactly one cycle; ihit or dhit=1 for the latched port only; next state IDLE.
//   The requester drops its request in RESP, so no duplicate issue; a still-high iREN in
//   the following IDLE cycle is a new fetch.
// - Min latency: request cycle N, ram_ready in N+1 -> hit in N+2.
// - Watchdog: counts cycles in DREQ/IREQ; on reaching TIMEOUT_CYC without ram_ready,
//   force RESP, load 32'hBAD1BAD1 into iload/dload (reads), set timeout=1.
// - Requests deasserted mid-transaction: access still completes; hit pulse still issued.
// - ram_ready outside DREQ/IREQ is ignored.
// - Simultaneous dREN/dWEN and iREN in IDLE: data wins; fetch waits until after RESP.
// CONFIGURATION
// - PERF_CNT_EN defined: icount/dcount increment in RESP per port; stallcount as defined;
//   all wrap at 2^32 to 0.
// - PERF_CNT_EN undefined: counters not built; icount,dcount,stallcount tied to 0.
// TESTING
// - Reset: nRST=0 two cycles with iREN=1, ram_ready=1 -> all outputs 0, no strobe.
// - Fetch: iREN=1 iaddr=0x40, ram_ready one cycle after ramREN, ramload=0x8C220004
//   -> ramREN high 1 cycle, ihit pulse 1 cycle later, iload=0x8C220004.
// - Priority: iREN=1 and dREN=1 daddr=0x100 same cycle, ramload=0xDEADBEEF -> data first,
//   dhit with dload=0xDEADBEEF, then fetch issued, ihit follows.
// - Write: dREN=1 dWEN=1 daddr=0x200 dstore=0x12345678, ram_ready after 3 cycles -> only
//   ramWEN high, ramstore=0x12345678, dhit pulse, dload unchanged.
// - Timeout: TIMEOUT_CYC=4, dREN=1, ram_ready=0 -> after 4 strobe cycles dhit, dload=0xBAD1BAD1,
//   timeout=1 and stays 1; nRST=0 mid-access on a later fetch drops ramREN next edge.
// - PERF_CNT_EN: 3 fetches + 2 reads, ram_ready 1 cycle after each strobe -> icount=3,
//   dcount=2, stallcount=10; without macro all counts 0.

Source files
------------

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//   Serialises instruction-fetch and data requests from the datapath onto a
//   single RAM port. Data requests win over fetches. Each access completes
//   with a one-cycle ihit/dhit pulse in the RESP state, and the load data is
//   registered. A watchdog forces completion of an access that hangs.
//
// Parameters
//   ADDR_W       address width (iaddr, daddr, ramaddr)
//   DATA_W       data width (dstore, ramstore, ramload, iload, dload)
//   TIMEOUT_CYC  max cycles spent in a RAM state before forced completion
//                (0 disables the watchdog)
//
// Ports
//   CLK, nRST            clock; synchronous active-low reset
//   iREN, iaddr          fetch request / address
//   dREN, dWEN, daddr,   data read/write request, address, write data
//   dstore
//   ihit, iload          fetch-complete pulse, fetched word (held)
//   dhit, dload          data-complete pulse, read word (held)
//   ramREN, ramWEN,      RAM strobes, address, write data (all registered)
//   ramaddr, ramstore
//   ramload, ram_ready   RAM read data, RAM completes access this cycle
//   timeout              sticky watchdog-expiry flag
//   icount, dcount,      performance counters (only built with PERF_CNT_EN,
//   stallcount           otherwise tied to 0)
//
// Build option
//   PERF_CNT_EN  when defined, the three performance counters are built.
// ---------------------------------------------------------------------------
module mem_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic              ihit,
  output logic [DATA_W-1:0] iload,
  output logic              dhit,
  output logic [DATA_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramstore,
  input  logic [DATA_W-1:0] ramload,
  input  logic              ram_ready,
  output logic              timeout,
  output logic [31:0]       icount,
  output logic [31:0]       dcount,
  output logic [31:0]       stallcount
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DREQ = 2'd1,
    IREQ = 2'd2,
    RESP = 2'd3
  } state_t;

  localparam logic [DATA_W-1:0] BAD_WORD = DATA_W'(32'hBAD1BAD1);
  // Last watchdog count value; the access is forced complete in that cycle.
  localparam logic [31:0]       WD_LAST  = 32'(TIMEOUT_CYC - 1);

  state_t              state_reg, state_next;
  logic [31:0]         wd_reg;
  logic                ramren_reg, ramwen_reg;
  logic                ihit_reg, dhit_reg, timeout_reg;
  logic [ADDR_W-1:0]   ramaddr_reg;
  logic [DATA_W-1:0]   ramstore_reg, iload_reg, dload_reg;

  logic                wd_expire;
  logic                ram_done;
  logic [DATA_W-1:0]   load_word;

  // Completion condition for the current RAM access. A real ram_ready in the
  // same cycle as expiry takes precedence, so the real data is returned.
  always_comb begin
    wd_expire = 1'b0;
    if (TIMEOUT_CYC != 0) begin
      wd_expire = (wd_reg == WD_LAST);
    end
    ram_done  = ram_ready | wd_expire;
    load_word = ram_ready ? ramload : BAD_WORD;
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE: begin
        if (dREN | dWEN) begin
          state_next = DREQ;
        end else if (iREN) begin
          state_next = IREQ;
        end
      end
      DREQ, IREQ: begin
        if (ram_done) begin
          state_next = RESP;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_reg    <= IDLE;
      wd_reg       <= '0;
      ramren_reg   <= 1'b0;
      ramwen_reg   <= 1'b0;
      ihit_reg     <= 1'b0;
      dhit_reg     <= 1'b0;
      timeout_reg  <= 1'b0;
      ramaddr_reg  <= '0;
      ramstore_reg <= '0;
      iload_reg    <= '0;
      dload_reg    <= '0;
    end else begin
      state_reg <= state_next;
      ihit_reg  <= 1'b0;
      dhit_reg  <= 1'b0;
      case (state_reg)
        IDLE: begin
          wd_reg <= '0;
          // Latch the winning request; the strobe registers double as the
          // latched operation (write whenever dWEN, regardless of dREN).
          if (dREN | dWEN) begin
            ramaddr_reg  <= daddr;
            ramstore_reg <= dstore;
            ramwen_reg   <= dWEN;
            ramren_reg   <= ~dWEN;
          end else if (iREN) begin
            ramaddr_reg  <= iaddr;
            ramwen_reg   <= 1'b0;
            ramren_reg   <= 1'b1;
          end
        end
        DREQ, IREQ: begin
          if (ram_done) begin
            ramren_reg <= 1'b0;
            ramwen_reg <= 1'b0;
            if (!ram_ready) begin
              timeout_reg <= 1'b1;
            end
            if (state_reg == DREQ) begin
              dhit_reg <= 1'b1;
              if (ramren_reg) begin
                dload_reg <= load_word;
              end
            end else begin
              ihit_reg  <= 1'b1;
              iload_reg <= load_word;
            end
          end else begin
            wd_reg <= wd_reg + 32'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign ihit     = ihit_reg;
  assign dhit     = dhit_reg;
  assign iload    = iload_reg;
  assign dload    = dload_reg;
  assign ramREN   = ramren_reg;
  assign ramWEN   = ramwen_reg;
  assign ramaddr  = ramaddr_reg;
  assign ramstore = ramstore_reg;
  assign timeout  = timeout_reg;

`ifdef PERF_CNT_EN
  // Counter 0: fetches, 1: data accesses, 2: stalled request cycles.
  // The hit registers are high exactly in RESP, so they mark completions.
  logic [2:0] cnt_inc;
  assign cnt_inc[0] = ihit_reg;
  assign cnt_inc[1] = dhit_reg;
  assign cnt_inc[2] = (iREN | dREN | dWEN) & ~(ihit_reg | dhit_reg);

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_cnt
      logic [31:0] cnt_reg;
      always_ff @(posedge CLK) begin
        if (!nRST) begin
          cnt_reg <= '0;
        end else if (cnt_inc[gi]) begin
          cnt_reg <= cnt_reg + 32'd1;
        end
      end
    end
  endgenerate

  assign icount     = g_cnt[0].cnt_reg;
  assign dcount     = g_cnt[1].cnt_reg;
  assign stallcount = g_cnt[2].cnt_reg;
`else
  assign icount     = '0;
  assign dcount     = '0;
  assign stallcount = '0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  localparam int TO = 4;
  localparam logic [31:0] BAD = 32'hBAD1BAD1;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore;
  logic        ihit, dhit;
  logic [31:0] iload, dload;
  logic        ramREN, ramWEN;
  logic [31:0] ramaddr, ramstore, ramload;
  logic        ram_ready;
  logic        timeout;
  logic [31:0] icount, dcount, stallcount;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(TO)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .ihit(ihit), .iload(iload), .dhit(dhit), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ram_ready(ram_ready),
    .timeout(timeout),
    .icount(icount), .dcount(dcount), .stallcount(stallcount)
  );

  always #5 CLK = ~CLK;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  // Behavioural reference: RAM contents plus the architecturally visible
  // results of completed transactions.
  logic [31:0] mem [logic [31:0]];
  logic [31:0] exp_iload, exp_dload;
  logic        exp_timeout;
  int unsigned exp_icnt, exp_dcnt, exp_stall;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    exp_iload   = '0;
    exp_dload   = '0;
    exp_timeout = 1'b0;
    exp_icnt    = 0;
    exp_dcnt    = 0;
    exp_stall   = 0;
  endtask

  // Advance one clock; a cycle with a request driven and no hit expected is a stall.
  task automatic tick(input bit hit_cycle);
    if (nRST && (iREN || dREN || dWEN) && !hit_cycle) exp_stall++;
    @(posedge CLK);
    #1;
  endtask

  task automatic check_counts(input string tag);
`ifdef PERF_CNT_EN
    check({tag, "_icount"},     icount,     exp_icnt);
    check({tag, "_dcount"},     dcount,     exp_dcnt);
    check({tag, "_stallcount"}, stallcount, exp_stall);
`else
    check({tag, "_icount"},     icount,     32'd0);
    check({tag, "_dcount"},     dcount,     32'd0);
    check({tag, "_stallcount"}, stallcount, 32'd0);
`endif
  endtask

  task automatic idle_cycles(input int n);
    iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
    for (int i = 0; i < n; i++) begin
      ram_ready = 1'($urandom_range(0, 1));  // must be ignored while idle
      ramload   = $urandom;
      check("idle_strobes", 32'({ramREN, ramWEN}), 32'd0);
      check("idle_hits",    32'({ihit, dhit}),     32'd0);
      tick(0);
    end
    ram_ready = 1'b0;
  endtask

  // One full transaction, starting in an IDLE cycle and ending in the IDLE
  // cycle after RESP. delay = strobe cycles before ram_ready (0 = first).
  task automatic do_txn(input bit is_data, input bit is_write, input logic [31:0] addr,
                        input logic [31:0] wdata, input int delay, input bit drop,
                        input bit also_fetch);
    bit          wr;
    bit          to;
    int          n_strobe;
    logic [31:0] rdata;
    wr = is_data && is_write;

    check("pre_hits",    32'({ihit, dhit}),     32'd0);
    check("pre_strobes", 32'({ramREN, ramWEN}), 32'd0);

    if (is_data) begin
      dWEN   = is_write;
      dREN   = is_write ? 1'($urandom_range(0, 1)) : 1'b1;
      daddr  = addr;
      dstore = wdata;
      iREN   = also_fetch;
      iaddr  = $urandom;
    end else begin
      iREN   = 1'b1;
      iaddr  = addr;
      dREN   = 1'b0;
      dWEN   = 1'b0;
      daddr  = $urandom;
      dstore = $urandom;
    end
    ram_ready = 1'($urandom_range(0, 1));  // still IDLE: ignored
    ramload   = $urandom;
    tick(0);

    to       = (delay >= TO);
    n_strobe = to ? TO : delay + 1;
    rdata    = mem.exists(addr) ? mem[addr] : $urandom;

    for (int k = 0; k < n_strobe; k++) begin
      check("ramREN",  32'(ramREN),  32'(!wr));
      check("ramWEN",  32'(ramWEN),  32'(wr));
      check("ramaddr", ramaddr, addr);
      if (wr) check("ramstore", ramstore, wdata);
      check("busy_hits", 32'({ihit, dhit}), 32'd0);
      ram_ready = (k == delay);
      ramload   = (k == delay) ? rdata : $urandom;
      if (drop && k == 0) begin
        if (is_data) begin
          dREN = 1'b0; dWEN = 1'b0;
        end else begin
          iREN = 1'b0;
        end
      end
      tick(0);
    end

    if (!wr) begin
      if (is_data) exp_dload = to ? BAD : rdata;
      else         exp_iload = to ? BAD : rdata;
      if (!to) mem[addr] = rdata;
    end else if (!to) begin
      mem[addr] = wdata;
    end
    if (to) exp_timeout = 1'b1;
    if (is_data) exp_dcnt++; else exp_icnt++;

    check("resp_dhit",    32'(dhit),    32'(is_data));
    check("resp_ihit",    32'(ihit),    32'(!is_data));
    check("resp_strobes", 32'({ramREN, ramWEN}), 32'd0);
    check("dload",        dload,        exp_dload);
    check("iload",        iload,        exp_iload);
    check("timeout",      32'(timeout), 32'(exp_timeout));
    $display("txn %s%s addr=0x%08h delay=%0d drop=%0d iload=0x%08h dload=0x%08h timeout=%0d",
             is_data ? "D" : "I", wr ? "W" : "R", addr, delay, drop, iload, dload, timeout);

    dREN = 1'b0; dWEN = 1'b0;
    iREN = also_fetch;
    ram_ready = 1'($urandom_range(0, 1));  // RESP: ignored
    tick(1);
    ram_ready = 1'b0;
  endtask

  task automatic do_reset(input int cycles);
    nRST = 1'b0; iREN = 1'b1; dREN = 1'b0; dWEN = 1'b0; ram_ready = 1'b1;
    repeat (cycles) begin
      @(posedge CLK);
      #1;
    end
    model_clear();
    iREN = 1'b0; ram_ready = 1'b0;
  endtask

  initial begin
    nRST = 1'b1; iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
    iaddr = '0; daddr = '0; dstore = '0; ramload = '0; ram_ready = 1'b0;
    model_clear();

    // Reset with a pending fetch and ram_ready asserted.
    do_reset(2);
    check("rst_hits",     32'({ihit, dhit}),     32'd0);
    check("rst_strobes",  32'({ramREN, ramWEN}), 32'd0);
    check("rst_ramaddr",  ramaddr,  32'd0);
    check("rst_ramstore", ramstore, 32'd0);
    check("rst_iload",    iload,    32'd0);
    check("rst_dload",    dload,    32'd0);
    check("rst_timeout",  32'(timeout), 32'd0);
    check_counts("rst");
    nRST = 1'b1;
    idle_cycles(1);

    // Minimum-latency fetch.
    mem[32'h40] = 32'h8C220004;
    do_txn(0, 0, 32'h40, 32'h0, 0, 0, 0);
    check("fetch_iload", iload, 32'h8C220004);

    // Data and fetch in the same cycle: data first, then the fetch.
    mem[32'h100] = 32'hDEADBEEF;
    do_txn(1, 0, 32'h100, 32'h0, 0, 0, 1);
    check("prio_dload", dload, 32'hDEADBEEF);
    do_txn(0, 0, 32'h44, 32'h0, 0, 0, 0);

    // Write with ram_ready on the third strobe cycle.
    do_txn(1, 1, 32'h200, 32'h12345678, 2, 0, 0);
    check("write_dload_kept", dload, 32'hDEADBEEF);

    // Watchdog expiry on a read, then stickiness across a normal fetch.
    do_txn(1, 0, 32'h300, 32'h0, 10, 0, 0);
    check("to_dload", dload, BAD);
    do_txn(0, 0, 32'h40, 32'h0, 1, 0, 0);
    check("to_sticky", 32'(timeout), 32'd1);

    // Reset in the middle of a fetch drops the strobe at the next edge.
    iREN = 1'b1; iaddr = 32'h80;
    tick(0);
    check("mid_ramREN_before", 32'(ramREN), 32'd1);
    nRST = 1'b0; iREN = 1'b0;
    @(posedge CLK);
    #1;
    model_clear();
    check("mid_ramREN_after", 32'(ramREN), 32'd0);
    check("mid_timeout",      32'(timeout), 32'd0);
    check("mid_iload",        iload, 32'd0);
    nRST = 1'b1;
    idle_cycles(1);

    // Counter scenario: 3 fetches + 2 reads at minimum latency.
    do_txn(0, 0, 32'h40, 32'h0, 0, 0, 0);
    do_txn(1, 0, 32'h100, 32'h0, 0, 0, 0);
    do_txn(0, 0, 32'h44, 32'h0, 0, 0, 0);
    do_txn(1, 0, 32'h200, 32'h0, 0, 0, 0);
    do_txn(0, 0, 32'h48, 32'h0, 0, 0, 0);
`ifdef PERF_CNT_EN
    check("perf_icount",     icount,     32'd3);
    check("perf_dcount",     dcount,     32'd2);
    check("perf_stallcount", stallcount, 32'd10);
`else
    check("perf_icount",     icount,     32'd0);
    check("perf_dcount",     dcount,     32'd0);
    check("perf_stallcount", stallcount, 32'd0);
`endif

    // Randomised traffic against the reference model.
    for (int i = 0; i < 60; i++) begin
      bit          rd_data, rd_write, rd_drop;
      logic [31:0] raddr;
      rd_data  = 1'($urandom_range(0, 1));
      rd_write = rd_data && ($urandom_range(0, 2) == 0);
      rd_drop  = ($urandom_range(0, 3) == 0);
      raddr    = 32'($urandom_range(0, 15)) << 2;
      do_txn(rd_data, rd_write, raddr, $urandom, int'($urandom_range(0, 5)), rd_drop, 0);
      idle_cycles(int'($urandom_range(0, 2)));
    end
    check_counts("final");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
